// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning the PC and IR,
// with run, single-step and sticky PC-breakpoint control.
module seq_ctrl #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   input  logic [7:0]       instr,
   input  logic [7:0]       alu_result,
   output logic [7:0]       pc,
   output logic [7:0]       ir,
   output logic [1:0]       rs_sel,
   output logic [1:0]       rt_sel,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wr_addr,
   output logic [7:0]       wr_data,
   output logic [2:0]       state,
   output logic             busy,
   output logic             bp_hit,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   state_t     st_r;
   logic       step_mode_r;
   logic [7:0] pc_next_s;

   // Opcode field to ALU op; opcode 2'b11 is the nop and maps to ALU op 0.
   function automatic logic [1:0] op_map(input logic [1:0] opc);
      logic [1:0] res;
      case (opc)
         2'b00:   res = 2'b01;
         2'b01:   res = 2'b10;
         2'b10:   res = 2'b11;
         default: res = 2'b00;
      endcase
      return res;
   endfunction

   assign pc_next_s = pc + 8'd1;
   assign rs_sel    = ir[5:4];
   assign rt_sel    = ir[3:2];
   assign wr_addr   = ir[1:0];
   assign state     = st_r;
   assign busy      = (st_r != IDLE);
   assign reg_write = (st_r == WRITEBACK) && (ir[7:6] != 2'b11);

   // Sequencer state, PC/IR, datapath latches and retired counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_r        <= IDLE;
         step_mode_r <= 1'b0;
         pc          <= PC_RESET;
         ir          <= 8'h00;
         alu_op      <= 2'b00;
         wr_data     <= 8'h00;
         bp_hit      <= 1'b0;
         retired     <= '0;
      end else begin
         case (st_r)
            IDLE: begin
               if (run) begin
                  st_r        <= FETCH;
                  step_mode_r <= 1'b0;
                  bp_hit      <= 1'b0;
               end else if (step) begin
                  st_r        <= FETCH;
                  step_mode_r <= 1'b1;
                  bp_hit      <= 1'b0;
               end else begin
                  st_r <= IDLE;
               end
            end
            FETCH: begin
               ir   <= instr;
               st_r <= DECODE;
            end
            DECODE: begin
               alu_op <= op_map(ir[7:6]);
               st_r   <= EXECUTE;
            end
            EXECUTE: begin
               wr_data <= alu_result;
               st_r    <= WRITEBACK;
            end
            WRITEBACK: begin
               pc      <= pc_next_s;
               retired <= retired + 1'b1;
               // Breakpoint compares against the incremented PC, so a restart at bp_addr runs through.
               if (step_mode_r || !run) begin
                  st_r <= IDLE;
               end else if (bp_en && (pc_next_s == bp_addr)) begin
                  st_r   <= IDLE;
                  bp_hit <= 1'b1;
               end else begin
                  st_r <= FETCH;
               end
            end
            default: begin
               st_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed steps with a write-back scoreboard
// (expected writes queued at stimulus time, popped when the DUT reaches WRITEBACK).
module tb_seq_ctrl;

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
      logic [1:0] op;
      logic       nop;
   } exp_t;

   logic        clk, rst, run, step, bp_en;
   logic [7:0]  bp_addr, instr, alu_result, alu_val;
   logic [7:0]  pc, ir, wr_data;
   logic [1:0]  rs_sel, rt_sel, alu_op, wr_addr;
   logic        reg_write, busy, bp_hit;
   logic [2:0]  state;
   logic [15:0] retired;

   logic        step_w;
   logic [7:0]  instr_w, pc_w, ir_w, wr_data_w;
   logic [1:0]  rs_sel_w, rt_sel_w, alu_op_w, wr_addr_w;
   logic        reg_write_w, busy_w, bp_hit_w;
   logic [2:0]  state_w;
   logic [15:0] retired_w;

   logic [7:0]  imem [256];
   exp_t        q [$];
   int          pulses [$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;

   assign instr      = imem[pc];
   assign instr_w    = imem[pc_w];
   assign alu_result = alu_val ^ {2'b00, rs_sel, rt_sel, 2'b00};

   seq_ctrl #(.PC_RESET(8'h00), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr),
      .instr(instr), .alu_result(alu_result), .pc(pc), .ir(ir), .rs_sel(rs_sel),
      .rt_sel(rt_sel), .alu_op(alu_op), .reg_write(reg_write), .wr_addr(wr_addr),
      .wr_data(wr_data), .state(state), .busy(busy), .bp_hit(bp_hit), .retired(retired)
   );

   seq_ctrl #(.PC_RESET(8'hFF), .CNT_W(16)) dut_w (
      .clk(clk), .rst(rst), .run(1'b0), .step(step_w), .bp_en(1'b0), .bp_addr(8'h00),
      .instr(instr_w), .alu_result(8'h00), .pc(pc_w), .ir(ir_w), .rs_sel(rs_sel_w),
      .rt_sel(rt_sel_w), .alu_op(alu_op_w), .reg_write(reg_write_w), .wr_addr(wr_addr_w),
      .wr_data(wr_data_w), .state(state_w), .busy(busy_w), .bp_hit(bp_hit_w), .retired(retired_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] op_of(input logic [1:0] opc);
      case (opc)
         2'b00:   return 2'b01;
         2'b01:   return 2'b10;
         2'b10:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic exp_t exp_of(input logic [7:0] ins);
      exp_t e;
      e.addr = ins[1:0];
      e.data = alu_val ^ {2'b00, ins[5:4], ins[3:2], 2'b00};
      e.op   = op_of(ins[7:6]);
      e.nop  = (ins[7:6] == 2'b11);
      return e;
   endfunction

   // Scoreboard monitor: every WRITEBACK cycle pops one expected write; elsewhere no strobe.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         if (reg_write === 1'b1) pulses.push_back(cyc);
         if (state === 3'd4) begin
            if (q.size() == 0) begin
               chk("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("wb_reg_write", {31'd0, reg_write}, {31'd0, !e.nop});
               chk("wb_alu_op", {30'd0, alu_op}, {30'd0, e.op});
               if (!e.nop) begin
                  chk("wb_wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
                  chk("wb_wr_data", {24'd0, wr_data}, {24'd0, e.data});
               end
            end
         end else begin
            chk("no_strobe_outside_wb", {31'd0, reg_write}, 32'd0);
         end
      end
   end

   initial begin
      rst = 1'b1; run = 1'b0; step = 1'b0; step_w = 1'b0;
      bp_en = 1'b0; bp_addr = 8'h00; alu_val = 8'h73;
      for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
      imem[0] = 8'h01; imem[1] = 8'h56; imem[2] = 8'h9B; imem[3] = 8'hC4;
      imem[255] = 8'h01;

      // Reset values
      tick(2);
      chk("rst_pc", pc, 32'h00);
      chk("rst_ir", ir, 32'h00);
      chk("rst_alu_op", alu_op, 32'h0);
      chk("rst_wr_data", wr_data, 32'h00);
      chk("rst_retired", retired, 32'h0);
      chk("rst_bp_hit", bp_hit, 32'h0);
      chk("rst_reg_write", reg_write, 32'h0);
      chk("rst_state", state, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_pc_w", pc_w, 32'hFF);
      rst = 1'b0;
      mon_en = 1'b1;

      // Single step of 8'h01 with alu_result 8'h73
      q.push_back(exp_of(imem[0]));
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("step_state1", state, 32'd1);
      chk("step_busy", busy, 32'd1);
      tick(1); chk("step_state2", state, 32'd2);
      tick(1); chk("step_state3", state, 32'd3);
      chk("step_alu_op", alu_op, 32'd1);
      tick(1); chk("step_state4", state, 32'd4);
      chk("step_reg_write", reg_write, 32'd1);
      chk("step_wr_addr", wr_addr, 32'd1);
      chk("step_wr_data", wr_data, 32'h73);
      chk("step_pc_before_wb_edge", pc, 32'd0);
      tick(1); chk("step_state0", state, 32'd0);
      chk("step_pc", pc, 32'd1);
      chk("step_retired", retired, 32'd1);
      tick(2); chk("step_stays_idle", state, 32'd0);

      // Continuous run: run held for 12 edges
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("run_pc_after_rst", pc, 32'd0);
      for (int i = 0; i < 3; i++) q.push_back(exp_of(imem[i]));
      pulses.delete();
      run = 1'b1;
      tick(12);
      run = 1'b0;
      tick(1);
      chk("run_state", state, 32'd0);
      chk("run_retired", retired, 32'd3);
      chk("run_pc", pc, 32'd3);
      chk("run_pulses", pulses.size(), 32'd3);
      if (pulses.size() == 3) begin
         chk("run_spacing1", pulses[1] - pulses[0], 32'd4);
         chk("run_spacing2", pulses[2] - pulses[1], 32'd4);
      end

      // Nop at pc 3
      q.push_back(exp_of(imem[3]));
      pulses.delete();
      step = 1'b1; tick(1); step = 1'b0;
      tick(4);
      chk("nop_state", state, 32'd0);
      chk("nop_alu_op", alu_op, 32'd0);
      chk("nop_pc", pc, 32'd4);
      chk("nop_retired", retired, 32'd4);
      chk("nop_no_pulse", pulses.size(), 32'd0);

      // Breakpoint at pc 2 with run held
      rst = 1'b1; tick(1); rst = 1'b0;
      bp_en = 1'b1; bp_addr = 8'h02;
      q.push_back(exp_of(imem[0]));
      q.push_back(exp_of(imem[1]));
      run = 1'b1;
      tick(1);
      for (int i = 0; i < 20 && state !== 3'd0; i++) tick(1);
      chk("bp_state", state, 32'd0);
      chk("bp_pc", pc, 32'd2);
      chk("bp_retired", retired, 32'd2);
      chk("bp_hit_set", bp_hit, 32'd1);
      q.push_back(exp_of(imem[2]));
      tick(1);
      chk("bp_restart_state", state, 32'd1);
      chk("bp_hit_cleared", bp_hit, 32'd0);
      run = 1'b0;
      tick(4);
      chk("bp_after_state", state, 32'd0);
      chk("bp_after_pc", pc, 32'd3);
      chk("bp_after_retired", retired, 32'd3);
      chk("bp_no_retrigger", bp_hit, 32'd0);
      bp_en = 1'b0;

      // PC wrap on the PC_RESET=8'hFF instance
      chk("wrap_pc_start", pc_w, 32'hFF);
      step_w = 1'b1; tick(1); step_w = 1'b0;
      tick(4);
      chk("wrap_state", state_w, 32'd0);
      chk("wrap_pc", pc_w, 32'h00);
      chk("wrap_retired", retired_w, 32'd1);

      // Reset during EXECUTE aborts the instruction
      imem[3] = 8'h27;
      pulses.delete();
      step = 1'b1; tick(1); step = 1'b0;
      tick(2);
      chk("abort_in_execute", state, 32'd3);
      rst = 1'b1; tick(1); rst = 1'b0;
      q.delete();
      chk("abort_state", state, 32'd0);
      chk("abort_pc", pc, 32'd0);
      chk("abort_retired", retired, 32'd0);
      chk("abort_ir", ir, 32'd0);
      chk("abort_wr_data", wr_data, 32'd0);
      tick(6);
      chk("abort_no_pulse", pulses.size(), 32'd0);
      chk("abort_idle", state, 32'd0);

      chk("sb_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the 8-bit processor datapath. It owns the program counter and instruction register and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. It drives the register-file select lines, ALU op and write strobe, and supports run, single-step and PC breakpoint control. It sits between the instruction memory, register file and ALU, replacing the single-cycle free-running PC.

## Interface
- PC_RESET, 8'h00, PC value loaded on reset
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- run  in  1  level; continuous execution while high
- step  in  1  pulse; execute exactly one instruction when sampled in IDLE
- bp_en  in  1  breakpoint enable
- bp_addr  in  8  breakpoint PC
- instr  in  8  instruction memory data at address pc (combinational)
- alu_result  in  8  ALU output for current rs_sel/rt_sel/alu_op
- pc  out  8  program counter, drives instruction memory address
- ir  out  8  instruction register
- rs_sel  out  2  ir[5:4]
- rt_sel  out  2  ir[3:2]
- alu_op  out  2  registered ALU op
- reg_write  out  1  register file write strobe
- wr_addr  out  2  ir[1:0]
- wr_data  out  8  latched ALU result
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4
- busy  out  1  state != IDLE
- bp_hit  out  1  sticky breakpoint flag
- retired  out  CNT_W  count of completed instructions

## Operation
- Reset values:
  - pc=PC_RESET.
  - ir, alu_op, wr_data, retired = 0; bp_hit=0; reg_write=0; state=IDLE.
  - The mode flag is cleared.
- IDLE:
  - run=1: go to FETCH in run mode and clear bp_hit.
  - Else step=1: go to FETCH in step mode and clear bp_hit.
  - run has priority over step.
  - step is ignored outside IDLE.
- FETCH: ir <= instr.
- DECODE: alu_op <= opcode map applied to ir[7:6]. 00→01 (add), 01→10 (sub), 10→11 (or), 11→00 (nop).
- EXECUTE: wr_data <= alu_result.
- WRITEBACK:
  - reg_write=1 iff ir[7:6] != 2'b11.
  - pc <= pc+1, mod 256 (8'hFF wraps to 8'h00).
  - retired <= retired+1, wraps at 2^CNT_W.
- Transition after WRITEBACK, evaluated against the incremented PC:
  - Step mode: go to IDLE.
  - Run mode with run=0: go to IDLE.
  - Run mode with bp_en=1 and next pc == bp_addr: go to IDLE and set bp_hit.
  - Otherwise: go to FETCH.
- The breakpoint check applies only on the WRITEBACK→FETCH path. Starting from IDLE at pc==bp_addr executes that instruction without re-triggering.
- rs_sel, rt_sel and wr_addr are combinational slices of ir.
- reg_write is combinational from state==WRITEBACK and the opcode, so it is high for exactly one cycle per non-nop instruction.
- rst in any state aborts the instruction: no write, no pc or retired update, and all reset values are applied on that edge.
- pc, ir, alu_op and wr_data change only in the states listed above.

## Timing
- 4 cycles per instruction; no pipelining.
- A start sampled in IDLE at edge N gives FETCH in cycle N+1 and WRITEBACK in cycle N+4.
- The register file captures wr_data on the edge ending WRITEBACK. The new pc is visible in the following cycle.
- Run mode with run held: back-to-back instructions every 4 cycles, with no IDLE cycles between them.
- Dropping run mid-instruction completes the current instruction, then the block goes to IDLE.
- alu_result must be valid in EXECUTE. rs_sel, rt_sel and alu_op are stable from DECODE+1 onward.

## Test plan
- **Single step:** reset; instr=8'h01 at pc 0; alu_result=8'h73; 1-cycle step.
  - state sequence 1,2,3,4,0.
  - reg_write high only in state 4, with wr_addr=1 and wr_data=8'h73.
  - Afterwards pc=1 and retired=1.
- **Continuous run:** hold run 12 cycles after reset, then deassert. Expect retired=3, pc=3, state=IDLE, and reg_write pulsed 3 times at 4-cycle spacing.
- **Nop:** instr=8'hC4, step. Expect alu_op=0, reg_write never high, pc+1, retired+1.
- **Breakpoint:** bp_en=1, bp_addr=2, run held.
  - Stops in IDLE with pc=2, retired=2, bp_hit=1.
  - Keeping run high restarts: bp_hit clears, the instruction at 2 executes, and pc reaches 3 with no re-trigger.
- **Wrap:** PC_RESET=8'hFF, step. Expect pc=8'h00 and retired=1.
- **Reset mid-op:** assert rst for one cycle while state=EXECUTE. Next cycle: state=0, pc=PC_RESET, retired=0, and no reg_write pulse ever occurs for the aborted instruction.
